// File: rtl/tiny_core_if.sv
// tiny_core_if: request/acknowledge memory bus between tiny_core and external memory
interface tiny_core_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/tiny_core.sv
// tiny_core: multi-cycle CPU core with wait-state memory port; TINY_CORE_OUT_EN enables the OUT port
module tiny_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  tiny_core_if.master       mem,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        flags,
  output logic              halted
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, IMM, MEM, HALT} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [9:0]        ir;
  logic [DATA_W-1:0] rf [8];
  logic [3:0]        op;
  logic [2:0]        rd, rs;
  logic [DATA_W-1:0] a, b, res, rf_wd;
  logic [DATA_W:0]   sum, dif;
  logic              ack, is_sub, c, v, rf_we, take;
  assign op     = ir[9:6];
  assign rd     = ir[5:3];
  assign rs     = ir[2:0];
  assign a      = rf[rd];
  assign b      = rf[rs];
  assign ack    = mem.mem_req && mem.mem_ack;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign dif    = {1'b0, a} - {1'b0, b};
  assign is_sub = op == 4'h6 || op == 4'hA;
  assign res    = op == 4'h4 ? b :
                  op == 4'h5 ? sum[DATA_W-1:0] :
                  is_sub     ? dif[DATA_W-1:0] :
                  op == 4'h7 ? a & b :
                  op == 4'h8 ? a | b : a ^ b;
  assign c      = op == 4'h5 ? sum[DATA_W] : is_sub ? dif[DATA_W] : 1'b0;
  assign v      = op == 4'h5 ? (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]) :
                  is_sub     ? (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]) : 1'b0;
  assign take   = op == 4'hB || (op == 4'hC && flags[0]) || (op == 4'hD && flags[1]);
  assign rf_we  = (state == EXEC && op >= 4'h4 && op <= 4'h9) ||
                  (ack && (state == IMM || (state == MEM && op == 4'h2)));
  assign rf_wd  = state == EXEC ? res : mem.mem_rdata;
  assign mem.mem_req   = state == FETCH || state == IMM || state == MEM;
  assign mem.mem_we    = state == MEM && op == 4'h3;
  assign mem.mem_addr  = state != MEM ? pc : op == 4'h3 ? a[ADDR_W-1:0] : b[ADDR_W-1:0];
  assign mem.mem_wdata = mem.mem_we ? b : '0;
  assign halted        = state == HALT;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next-state decode: memory states wait for ack, EXEC dispatches on opcode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   state_nx = ack ? EXEC : FETCH;
      EXEC:    state_nx = op == 4'h1 ? IMM : (op == 4'h2 || op == 4'h3) ? MEM : op == 4'hF ? HALT : FETCH;
      IMM:     state_nx = ack ? FETCH : IMM;
      MEM:     state_nx = ack ? FETCH : MEM;
      default: state_nx = HALT;
    endcase
  end
  // program counter, instruction and flags; only the opcode/rd/rs bits of IR are kept
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc    <= '0;
      ir    <= '0;
      flags <= '0;
    end else begin
      if (state == FETCH && ack) ir <= mem.mem_rdata[15:6];
      if ((state == FETCH || state == IMM) && ack) pc <= pc + 1'b1;
      else if (state == EXEC && take) pc <= b[ADDR_W-1:0];
      if (state == EXEC && op >= 4'h5 && op <= 4'hA) flags <= {res[DATA_W-1], v, c, res == '0};
    end
  // register file: single write port shared by ALU/MOV results and memory loads
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 8; i++) rf[i] <= '0;
    else if (rf_we) rf[rd] <= rf_wd;
`ifdef TINY_CORE_OUT_EN
  // output port: pulse valid the cycle after OUT executes, hold the data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= state == EXEC && op == 4'hE;
      if (state == EXEC && op == 4'hE) out_data <= b;
    end
`else
  assign out_valid = 1'b0;
  assign out_data  = '0;
`endif
endmodule

// File: tb/tb_tiny_core.sv
// tb_tiny_core: directed programs against a wait-state memory model for tiny_core
module tb_tiny_core;
  logic        clk = 0;
  logic        rst = 0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  flags;
  logic        halted;
  logic [15:0] mem [0:65535];
  int          waits = 0, cnt = 0, writes = 0, pulses = 0, stab_err = 0;
  int          passed = 0, total = 0, cyc, first;
  logic [15:0] w_addr, w_data, prev_addr;
  logic        prev_wait = 0;
  tiny_core_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  tiny_core #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .mem(bus), .out_valid(out_valid),
    .out_data(out_data), .flags(flags), .halted(halted)
  );
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];
  // ack after the programmed number of wait cycles
  always @(negedge clk) bus.mem_ack = bus.mem_req && cnt >= waits;
  // memory side: perform transfers, track waits, bus stability and OUT pulses
  always @(posedge clk) begin
    if (prev_wait && bus.mem_req && bus.mem_addr != prev_addr) stab_err++;
    prev_wait = bus.mem_req && !bus.mem_ack;
    prev_addr = bus.mem_addr;
    if (bus.mem_req && bus.mem_ack) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] = bus.mem_wdata;
        writes++;
        w_addr = bus.mem_addr;
        w_data = bus.mem_wdata;
      end
      cnt = 0;
    end else if (bus.mem_req) cnt++;
    else cnt = 0;
    if (out_valid) pulses++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic load(input logic [15:0] p[$]);
    foreach (mem[i]) mem[i] = 16'h0;
    foreach (p[i]) mem[i] = p[i];
  endtask
  // reset, release on a falling edge, then count rising edges until halted
  task automatic run(input int w, output int n, output int f);
    rst = 0;
    waits = w;
    repeat (2) @(negedge clk);
    writes = 0;
    pulses = 0;
    stab_err = 0;
    rst = 1;
    n = 0;
    f = -1;
    while (!halted && n < 500) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.mem_req && f < 0) f = n;
    end
    if (!halted) check("halt_timeout", 0, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", flags, 0);
    check("rst_halted", halted, 0);
    load('{16'h1200, 16'h0005, 16'h1400, 16'h0003, 16'h5280, 16'hF000});
    run(0, cyc, first);
    check("boot_first_req", first, 1);
    check("boot_cycles", cyc, 11);
    check("boot_r1", dut.rf[1], 16'h0008);
    check("boot_flags", flags, 4'b0000);
    check("boot_halted", halted, 1);
    load('{16'h1200, 16'h7FFF, 16'h1400, 16'h0001, 16'h5280, 16'hF000});
    run(0, cyc, first);
    check("add_ovf_r1", dut.rf[1], 16'h8000);
    check("add_ovf_flags", flags, 4'b1100);
    load('{16'h1200, 16'h7FFF, 16'h1400, 16'h0001, 16'h5280, 16'hA240, 16'hF000});
    run(0, cyc, first);
    check("cmp_self_flags", flags, 4'b0001);
    check("cmp_self_r1", dut.rf[1], 16'h8000);
    load('{16'h1800, 16'h0020, 16'h2700, 16'hF000});
    mem[16'h0020] = 16'hBEEF;
    run(3, cyc, first);
    check("ld_wait_r3", dut.rf[3], 16'hBEEF);
    check("ld_wait_cycles", cyc, 24);
    check("ld_wait_stable", stab_err, 0);
    load('{16'h1A00, 16'h0040, 16'h1200, 16'h0007, 16'h1400, 16'h0007, 16'h6280, 16'hC140,
           16'h1600, 16'h0099, 16'hF000});
    mem[16'h0040] = 16'hF000;
    run(0, cyc, first);
    check("jz_taken_pc", dut.pc, 16'h0041);
    check("jz_taken_r3", dut.rf[3], 16'h0000);
    check("jz_taken_flags", flags, 4'b0001);
    mem[5] = 16'h0006;
    run(0, cyc, first);
    check("jz_fall_pc", dut.pc, 16'h000B);
    check("jz_fall_r3", dut.rf[3], 16'h0099);
    load('{16'h1200, 16'h0001, 16'h5440, 16'h1A00, 16'hFFFF, 16'hA440, 16'hC140, 16'hF000});
    run(0, cyc, first);
    check("wrap_r2", dut.rf[2], 16'h0002);
    check("wrap_pc", dut.pc, 16'h0008);
    load('{16'h1C00, 16'h0010, 16'h1E00, 16'h1234, 16'h3DC0, 16'hE1C0, 16'hF000});
    run(0, cyc, first);
    check("st_writes", writes, 1);
    check("st_addr", w_addr, 16'h0010);
    check("st_data", w_data, 16'h1234);
    check("st_mem", mem[16'h0010], 16'h1234);
`ifdef TINY_CORE_OUT_EN
    check("out_pulses", pulses, 1);
    check("out_data", out_data, 16'h1234);
`else
    check("out_pulses", pulses, 0);
    check("out_data", out_data, 16'h0000);
`endif
    load('{16'h1200, 16'h0005, 16'h1400, 16'h0003, 16'h5280, 16'hF000});
    rst = 0;
    waits = 10;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (15) @(posedge clk);
    #1;
    check("mid_req_pending", bus.mem_req, 1);
    check("mid_addr_pending", bus.mem_addr, 16'h0001);
    #2 rst = 0;
    #1;
    check("mid_rst_req", bus.mem_req, 0);
    check("mid_rst_addr", bus.mem_addr, 0);
    check("mid_rst_halted", halted, 0);
    run(0, cyc, first);
    check("restart_cycles", cyc, 11);
    check("restart_r1", dut.rf[1], 16'h0008);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tiny_core.md
# tiny_core

Parametrised single-issue CPU core: the successor to the fixed 16-bit shared-bus machine. It integrates the register file, ALU and fetch/execute controller behind one multi-cycle state machine. Data and address widths are configurable. External memory is reached through a request/acknowledge port that tolerates wait states. It sits below the board top, which supplies clock, reset, memory and the optional output port.

## Interface
- `DATA_W`, 16: datapath, register and instruction width (≥16; instruction fields use bits [15:0]; upper bits ignored in opcodes).
- `ADDR_W`, 16: program counter and memory address width (≤ DATA_W).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_req` out 1: memory transfer request; held until acknowledged.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`.
- `mem_addr` out ADDR_W: transfer address.
- `mem_wdata` out DATA_W: write data.
- `mem_rdata` in DATA_W: read data, sampled on the ack cycle.
- `mem_ack` in 1: completes the transfer in any cycle where `mem_req && mem_ack`.
- `out_valid` out 1: one-cycle pulse on OUT.
- `out_data` out DATA_W: OUT value, held until the next OUT.
- `flags` out 4: {N,V,C,Z}.
- `halted` out 1: core stopped by HLT.

## Operation
- Instruction fields: [15:12] opcode, [11:9] rd, [8:6] rs. 8 registers r0–r7, all general-purpose.
- Opcodes:
  - 0 NOP.
  - 1 LDI rd: the next word loads into rd; PC advances 2.
  - 2 LD rd,[rs].
  - 3 ST [rd],rs.
  - 4 MOV rd,rs.
  - 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR: rd = rd op rs.
  - A CMP: computes rd−rs; updates flags only.
  - B JMP rs.
  - C JZ rs.
  - D JC rs.
  - E OUT rs.
  - F HLT.
- Jump target is rs[ADDR_W-1:0]. An untaken jump falls through.
- Flags are written only by opcodes 5–A:
  - Z = result==0; N = result MSB.
  - ADD: C = carry out; V = signed overflow.
  - SUB/CMP: C = borrow (rd<rs unsigned); V = signed overflow.
  - Logic ops clear C and V.
- Arithmetic is modulo 2^DATA_W. PC increments modulo 2^ADDR_W, so a fetch from all-ones wraps to 0. Addresses from registers are truncated to ADDR_W.
- State machine:
  - IDLE → FETCH unconditionally.
  - FETCH: `mem_req`=1, address PC. On ack, latch IR, PC+1, → EXEC.
  - EXEC:
    - ALU/MOV/jump/OUT/NOP complete here → FETCH.
    - LDI → IMM.
    - LD/ST → MEM.
    - HLT → HALT.
  - IMM: read at PC. On ack, write rd, PC+1 → FETCH.
  - MEM: read or write at the register address. On ack, LD writes rd → FETCH.
  - HALT: terminal. `halted`=1, no requests, until reset.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from state/registers and change only on clock edges.
- Reset (any time, including mid-transfer): state IDLE, PC=0, r0–r7=0, flags=0, IR=0. A pending request is abandoned.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `out_valid`=0, `out_data`=0, `flags`=0, `halted`=0.
- The first fetch request appears one cycle after `rst` deasserts (IDLE cycle).
- Latencies with zero-wait memory (`mem_ack` tied 1):
  - ALU/MOV/jump/OUT/NOP: 2 cycles.
  - LD/ST/LDI: 3 cycles.
  - Each wait cycle adds 1.
- Register writes and flags are visible to the next instruction's EXEC; no hazards.
- `out_valid` pulses in the cycle after EXEC of OUT. `out_data` updates in the same cycle.
- `mem_ack` with `mem_req`=0 is ignored.
- `mem_rdata` is don't-care outside read ack cycles.

## Configuration
- `TINY_CORE_OUT_EN` defined: opcode E drives `out_valid`/`out_data` as above.
- Not defined:
  - Opcode E executes as NOP.
  - `out_valid` and `out_data` are tied 0.
  - The output register is not synthesised.

## Test plan
- Reset/boot, zero-wait: program LDI r1,#5; LDI r2,#3; ADD r1,r2; HLT.
  - r1=8, flags=0000, `halted`=1.
  - First `mem_req` occurs 1 cycle after reset release; total 11 cycles to `halted`.
- Flags, DATA_W=16: LDI r1,#0x7FFF; LDI r2,#1; ADD r1,r2.
  - r1=0x8000, N=1, V=1, C=0, Z=0.
  - Follow with CMP r1,r1: Z=1, C=0, N=0, V=0; r1 unchanged.
- Wait states: `mem_ack` delayed 3 cycles on every transfer for LD r3,[r4] with mem[0x20]=0xBEEF.
  - r3=0xBEEF.
  - `mem_req`/`mem_addr` stay stable throughout the wait.
  - LD takes 9 cycles.
- Branching: SUB producing 0, then JZ r5 with r5=0x40.
  - The next fetch address is 0x40.
  - With Z=0, fetch falls through to PC+1.
  - PC at 0xFFFF (ADDR_W=16) wraps to 0x0000.
- Store and output: ST [r6],r7 with r6=0x10, r7=0x1234.
  - One write with `mem_we`=1, addr 0x10, data 0x1234.
  - OUT r7 pulses `out_valid` for exactly 1 cycle with `out_data`=0x1234 when `TINY_CORE_OUT_EN` is defined; both stay 0 when it is not.
- Reset mid-transfer: assert `rst` low while `mem_req`=1 awaiting ack.
  - All outputs return to reset values asynchronously.
  - Execution restarts at PC=0 after release.
